// File: rtl/rggen_event_coalescer_if.sv
// Bus bundle for rggen_event_coalescer: raw events, lane controls, set pulses and pending counts.
// master = event source / register side, slave = coalescer.
interface rggen_event_coalescer_if #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 16
);
  logic [WIDTH-1:0]             i_event;
  logic [WIDTH-1:0]             i_enable;
  logic [COUNT_WIDTH-1:0]       i_threshold;
  logic [TIMER_WIDTH-1:0]       i_timeout;
  logic [WIDTH-1:0]             o_set_or_clear;
  logic [WIDTH*COUNT_WIDTH-1:0] o_pending_count;

  modport master (
    output i_event, i_enable, i_threshold, i_timeout,
    input  o_set_or_clear, o_pending_count
  );

  modport slave (
    input  i_event, i_enable, i_threshold, i_timeout,
    output o_set_or_clear, o_pending_count
  );
endinterface

// File: rtl/rggen_event_coalescer.sv
// Per-lane event synchronizer, rising-edge detector and threshold/timeout coalescer driving W1C set pulses.
// Optional timeout rule enabled by defining RGGEN_EVENT_COALESCER_TIMEOUT_EN.
module rggen_event_coalescer #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned TIMER_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  rggen_event_coalescer_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  logic [WIDTH-1:0]             r_sync [SYNC_STAGES];
  logic [WIDTH-1:0]             r_sync_d;
  logic [WIDTH-1:0]             w_edge;
  logic [WIDTH-1:0]             w_pulse;
  logic [COUNT_WIDTH-1:0]       w_thr;
  logic [WIDTH*COUNT_WIDTH-1:0] w_count;

  // Synchronizer chain keeps running regardless of enable so re-enabling never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= bus.i_event;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d & bus.i_enable;
  assign w_thr  = (bus.i_threshold == '0) ? COUNT_WIDTH'(1) : bus.i_threshold;

`ifndef RGGEN_EVENT_COALESCER_TIMEOUT_EN
  logic w_unused_timeout;
  assign w_unused_timeout = ^bus.i_timeout;
`endif

  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_next;
    logic                   r_pulse;
    logic                   w_timeout_hit;
    logic                   w_fire;

    assign w_next = (r_count == '1) ? r_count : r_count + COUNT_WIDTH'(w_edge[n]);

`ifdef RGGEN_EVENT_COALESCER_TIMEOUT_EN
    logic [TIMER_WIDTH-1:0] r_timer;

    assign w_timeout_hit = (r_state == ST_ACCUM) && (bus.i_timeout != '0) &&
                           (r_timer == bus.i_timeout - TIMER_WIDTH'(1));

    // Age of the current batch; held at zero outside ACCUM
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_timer <= '0;
      end else if (!bus.i_enable[n] || (r_state != ST_ACCUM) || w_fire) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + TIMER_WIDTH'(1);
      end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    assign w_fire = (w_next >= w_thr) || w_timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!bus.i_enable[n]) begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_edge[n]) begin
                if (w_thr == COUNT_WIDTH'(1)) begin
                  r_pulse <= 1'b1;
                  r_count <= '0;
                end else begin
                  r_count <= COUNT_WIDTH'(1);
                  r_state <= ST_ACCUM;
                end
              end
            end
            ST_ACCUM: begin
              // A coincident event is absorbed into the pulse fired here
              if (w_fire) begin
                r_pulse <= 1'b1;
                r_count <= '0;
                r_state <= ST_IDLE;
              end else begin
                r_count <= w_next;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_count <= '0;
            end
          endcase
        end
      end
    end

    assign w_pulse[n]                           = r_pulse;
    assign w_count[n*COUNT_WIDTH +: COUNT_WIDTH] = r_count;
  end

  assign bus.o_set_or_clear  = w_pulse;
  assign bus.o_pending_count = w_count;

endmodule

// File: tb/tb_rggen_event_coalescer.sv
// Randomized self-checking bench for rggen_event_coalescer against a batch-level reference model.
// Expectations follow RGGEN_EVENT_COALESCER_TIMEOUT_EN when it is defined for the build.
module tb_rggen_event_coalescer;
  localparam int unsigned W  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef RGGEN_EVENT_COALESCER_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_event_coalescer_if #(.WIDTH(W), .COUNT_WIDTH(CW), .TIMER_WIDTH(TW)) bus ();
  rggen_event_coalescer #(.WIDTH(W), .SYNC_STAGES(S), .COUNT_WIDTH(CW), .TIMER_WIDTH(TW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: sampled-input history plus per-lane batch (pending count, age since first event)
  bit [S:0]     m_hist [W];
  int           m_cnt  [W];
  int           m_age  [W];
  bit           m_act  [W];
  bit [W-1:0]   m_pulse;

  task automatic model_reset();
    for (int l = 0; l < W; l++) begin
      m_hist[l] = '0; m_cnt[l] = 0; m_age[l] = 0; m_act[l] = 1'b0;
    end
    m_pulse = '0;
  endtask

  task automatic model_step(input logic [W-1:0] ev, input logic [W-1:0] en,
                            input logic [CW-1:0] th, input logic [TW-1:0] tmo);
    int thr;
    int nxt;
    bit det;
    thr = (th == '0) ? 1 : int'(th);
    m_pulse = '0;
    for (int l = 0; l < W; l++) begin
      // Input sampled S edges ago is the synchronized level now; one more back is its delayed copy
      det = en[l] && m_hist[l][S-1] && !m_hist[l][S];
      m_hist[l] = {m_hist[l][S-1:0], ev[l]};
      if (!en[l]) begin
        m_cnt[l] = 0; m_age[l] = 0; m_act[l] = 1'b0;
      end else if (!m_act[l]) begin
        if (det) begin
          if (thr == 1) m_pulse[l] = 1'b1;
          else begin m_cnt[l] = 1; m_age[l] = 0; m_act[l] = 1'b1; end
        end
      end else begin
        nxt = m_cnt[l] + int'(det);
        if (nxt > CMAX) nxt = CMAX;
        m_age[l]++;
        if (nxt >= thr || (TO && tmo != '0 && m_age[l] == int'(tmo))) begin
          m_pulse[l] = 1'b1; m_cnt[l] = 0; m_act[l] = 1'b0;
        end else begin
          m_cnt[l] = nxt;
        end
      end
    end
  endtask

  function automatic logic [W*CW-1:0] exp_pend();
    logic [W*CW-1:0] v;
    for (int l = 0; l < W; l++) v[l*CW +: CW] = CW'(m_cnt[l]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(bus.i_event, bus.i_enable, bus.i_threshold, bus.i_timeout);
    #1;
  endtask

  task automatic settle();
    bus.i_event = '0;
    bus.i_enable = '0;
    repeat (S + 2) tick();
    bus.i_enable = '1;
  endtask

  task automatic test_reset();
    bus.i_event = '0; bus.i_enable = '1; bus.i_threshold = '0; bus.i_timeout = '0;
    model_reset();
    #12;
    n_total++;
    if (bus.o_set_or_clear !== '0 || bus.o_pending_count !== '0) begin
      n_bad++;
      $display("FAIL reset_state: set=%b pend=%h required 0/0", bus.o_set_or_clear, bus.o_pending_count);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL reset_idle cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
    end
  endtask

  task automatic test_basic_edge();
    int first, npulse;
    settle();
    bus.i_threshold = '0;
    first = -1; npulse = 0;
    for (int i = 0; i < 14; i++) begin
      bus.i_event[0] = (i < 10);
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL basic cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
      if (bus.o_set_or_clear[0]) begin npulse++; if (first < 0) first = i; end
    end
    n_total++;
    if (npulse !== 1 || first !== 2) begin
      n_bad++;
      $display("FAIL basic_latency: pulses=%0d at=%0d required 1 at 2", npulse, first);
    end
  endtask

  task automatic test_threshold();
    int npulse;
    settle();
    bus.i_threshold = CW'(3);
    npulse = 0;
    for (int i = 0; i < 32; i++) begin
      bus.i_event[0] = (i < 28) && ((i % 4) < 2);
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL threshold cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
      if (bus.o_set_or_clear[0]) npulse++;
    end
    n_total++;
    if (npulse !== 2 || bus.o_pending_count[CW-1:0] !== CW'(1)) begin
      n_bad++;
      $display("FAIL threshold_summary: pulses=%0d pend=%0d required 2/1", npulse, bus.o_pending_count[CW-1:0]);
    end
  endtask

  task automatic test_timeout();
    int npulse, at;
    settle();
    bus.i_threshold = CW'(5); bus.i_timeout = TW'(20);
    npulse = 0; at = -1;
    for (int i = 0; i < 30; i++) begin
      bus.i_event[0] = (i < 8) && ((i % 4) < 2);
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL timeout cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
      if (bus.o_set_or_clear[0]) begin npulse++; at = i; end
    end
    n_total++;
    if (npulse !== (TO ? 1 : 0) || at !== (TO ? 22 : -1) || bus.o_pending_count[CW-1:0] !== CW'(TO ? 0 : 2)) begin
      n_bad++;
      $display("FAIL timeout_summary: pulses=%0d at=%0d pend=%0d required %0d/%0d/%0d", npulse, at,
               bus.o_pending_count[CW-1:0], TO ? 1 : 0, TO ? 22 : -1, TO ? 0 : 2);
    end
    bus.i_timeout = '0;
  endtask

  task automatic test_simultaneous();
    int npulse;
    settle();
    bus.i_threshold = CW'(4); bus.i_timeout = TW'(10);
    npulse = 0;
    for (int i = 0; i < 22; i++) begin
      bus.i_event[0] = (i == 0 || i == 1 || i == 4 || i == 5 || i == 10 || i == 11 || i == 16 || i == 17);
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL simultaneous cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
      if (bus.o_set_or_clear[0]) npulse++;
    end
    n_total++;
    if (npulse !== 1 || bus.o_pending_count[CW-1:0] !== CW'(TO ? 1 : 0)) begin
      n_bad++;
      $display("FAIL simultaneous_summary: pulses=%0d pend=%0d required 1/%0d", npulse, bus.o_pending_count[CW-1:0], TO ? 1 : 0);
    end
    bus.i_timeout = '0;
  endtask

  task automatic test_disable_reset();
    settle();
    bus.i_threshold = CW'(4);
    for (int i = 0; i < 8; i++) begin
      bus.i_event[0] = (i % 4) < 2;
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL disable cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
    end
    n_total++;
    if (bus.o_pending_count[CW-1:0] !== CW'(2)) begin
      n_bad++;
      $display("FAIL disable_pending: pend=%0d required 2", bus.o_pending_count[CW-1:0]);
    end
    bus.i_enable[0] = 1'b0;
    tick(); n_total++;
    if (bus.o_set_or_clear[0] !== 1'b0 || bus.o_pending_count[CW-1:0] !== '0 || bus.o_pending_count !== exp_pend()) begin
      n_bad++;
      $display("FAIL disable_clear: set=%b pend=%h required 0/%h", bus.o_set_or_clear, bus.o_pending_count, exp_pend());
    end
    bus.i_enable[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.i_event[0] = (i % 4) < 2;
      tick();
    end
    n_total++;
    if (bus.o_pending_count[CW-1:0] !== CW'(2)) begin
      n_bad++;
      $display("FAIL rebatch_pending: pend=%0d required 2", bus.o_pending_count[CW-1:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.o_set_or_clear !== '0 || bus.o_pending_count !== '0) begin
      n_bad++;
      $display("FAIL async_reset: set=%b pend=%h required 0/0", bus.o_set_or_clear, bus.o_pending_count);
    end
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL post_reset cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
    end
  endtask

  task automatic test_multi_lane();
    int nfire;
    logic [W-1:0] seen;
    settle();
    bus.i_threshold = CW'(1);
    bus.i_enable = 4'b1101;
    nfire = 0; seen = '0;
    for (int i = 0; i < 8; i++) begin
      bus.i_event = (i < 6) ? 4'b0111 : 4'b0000;
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL multi cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
      if (bus.o_set_or_clear !== '0) begin nfire++; seen = bus.o_set_or_clear; end
    end
    n_total++;
    if (nfire !== 1 || seen !== 4'b0101) begin
      n_bad++;
      $display("FAIL multi_summary: cycles=%0d set=%b required 1/0101", nfire, seen);
    end
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 1200; i++) begin
      if (i % 100 == 0) begin
        bus.i_threshold = CW'($urandom_range(0, 4));
        bus.i_timeout   = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 12));
      end
      bus.i_event = W'($urandom);
      for (int l = 0; l < W; l++) bus.i_enable[l] = ($urandom_range(0, 31) != 0);
      tick(); n_total++;
      if (bus.o_set_or_clear !== m_pulse || bus.o_pending_count !== exp_pend()) begin
        n_bad++;
        $display("FAIL random cyc%0d: set=%b pend=%h required %b/%h", i, bus.o_set_or_clear, bus.o_pending_count, m_pulse, exp_pend());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_threshold();
    test_timeout();
    test_simultaneous();
    test_disable_reset();
    test_multi_lane();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/rggen_event_coalescer.md
# rggen_event_coalescer

Hardware-side front end for interrupt/status bit fields. Synchronizes raw per-lane event inputs, detects rising edges, and coalesces events per lane by count threshold and, optionally, a timeout. It emits one-cycle set pulses that drive `i_set_or_clear` of a `rggen_bit_field_w01s_w01c` instance built with `MODE = RGGEN_CLEAR_MODE` (hardware sets, software writes to clear).

## Interface
- WIDTH, 1, number of independent event lanes
- SYNC_STAGES, 2, synchronizer depth per lane; legal range ≥2
- COUNT_WIDTH, 8, width of per-lane event counter and of threshold
- TIMER_WIDTH, 16, width of per-lane timeout timer and of timeout value

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- i_event  input  WIDTH  raw event levels; asynchronous to clk
- i_enable  input  WIDTH  per-lane enable; must be quasi-static, e.g. from a register field
- i_threshold  input  COUNT_WIDTH  events per pulse, shared by all lanes; 0 treated as 1
- i_timeout  input  TIMER_WIDTH  cycles from first pending event to forced pulse; 0 = timeout disabled
- o_set_or_clear  output  WIDTH  one-cycle set pulse per lane; connect to the W1C field
- o_pending_count  output  WIDTH*COUNT_WIDTH  per-lane pending event count; lane n occupies bits [n*COUNT_WIDTH +: COUNT_WIDTH]

## Operation
- Per lane: SYNC_STAGES-flop synchronizer to s; s_d is s delayed one cycle; edge = s & ~s_d & i_enable.
- Per-lane FSM, states IDLE and ACCUM. Registers: count (COUNT_WIDTH bits), timer (TIMER_WIDTH bits), and pulse, which drives o_set_or_clear.
- thr = max(i_threshold, 1). next = count + edge, saturating at 2^COUNT_WIDTH−1.
- IDLE, edge, thr = 1: pulse←1, count←0, stay IDLE.
- IDLE, edge, thr > 1: count←1, timer←0, go to ACCUM.
- ACCUM, next ≥ thr: pulse←1, count←0, timer←0, go to IDLE. The ≥ comparison means lowering i_threshold below count fires on the next edge.
- ACCUM, timeout enabled, i_timeout ≠ 0 and timer = i_timeout−1: pulse←1, count←0, timer←0, go to IDLE. An event in the same cycle is absorbed into this pulse.
- Otherwise in ACCUM: count←next, timer←timer+1, saturating.
- pulse is 0 in every cycle not listed above.
- i_enable low: lane forced to IDLE, count←0, timer←0, pulse←0. Synchronizer flops keep running, so re-enabling while the input is high produces no spurious edge.
- Lanes are fully independent. No cross-lane arbitration.

## Timing
- Reset values:
  - o_set_or_clear = 0
  - o_pending_count = 0
  - all synchronizer flops, s_d, timer = 0
  - FSM = IDLE
- Latency:
  - i_event is first sampled high at edge k.
  - s goes high after edge k+SYNC_STAGES−1.
  - With thr = 1, o_set_or_clear is high for exactly one cycle after edge k+SYNC_STAGES.
- Timeout: if count becomes 1 at edge e, the pulse is asserted after edge e+i_timeout, unless the threshold fires earlier.
- Back-to-back: an edge in the cycle right after a pulse starts a new batch. No event is lost.
- Minimum event spacing is 2 cycles low/high at the input for guaranteed edge detection.
- Reset asserted mid-accumulation discards the pending count. No pulse is produced at reset.

## Configuration
- RGGEN_EVENT_COALESCER_TIMEOUT_EN defined: timer registers and the timeout rule are present.
- Undefined:
  - timer logic is not instantiated
  - i_timeout is ignored
  - pulses occur only on the threshold rule
  - port list is unchanged

## Test plan
- Basic edge: WIDTH=1, SYNC_STAGES=2, i_threshold=0, single rising edge of i_event, held high 10 cycles -> exactly one 1-cycle pulse, 2 edges after first sampling. o_pending_count stays 0.
- Threshold: i_threshold=3, 7 events spaced 4 cycles apart -> pulses after the 3rd and 6th detected edges. o_pending_count reads 1 after the 7th.
- Timeout (macro defined): i_threshold=5, i_timeout=20, 2 events -> one pulse 20 cycles after count became 1. Count returns to 0. Macro undefined: no pulse, count holds 2.
- Simultaneous: i_threshold=4, i_timeout=10, 3rd event arrives in the timeout cycle -> single pulse. Next event starts count at 1.
- Disable/reset: i_threshold=4, 2 pending events, then drop i_enable for 1 cycle -> count 0, no pulse. Repeat with rst_n pulsed low mid-batch -> all outputs 0 asynchronously.
- Multi-lane: WIDTH=4, lanes 0 and 2 fire in the same cycle, lane 1 disabled -> o_set_or_clear = 4'b0101 for one cycle.
